axi4_burst_reader: RTL and testbench

- Single-ID AXI4 read initiator that fetches a contiguous word region and presents it on a valid/ready output stream.
- A command (start address, beat count) is split into INCR bursts of at most MAX_BURST_LEN beats; no burst crosses a 4KB boundary.
- Used by DMA/loader blocks to drain the ROM/SRAM slave units on the system interconnect.
- Write channels are tied off.

---
 rtl/axi4_burst_reader_if.sv | 78 +++++++
 rtl/axi4_burst_reader.sv | 194 +++++++++++++++++++
 tb/tb_axi4_burst_reader.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_burst_reader_if.sv
// AXI4 interface bundle used by axi4_burst_reader and its attached slave.
// Carries all five channels; the master/slave modports fix the signal directions.
interface axi4_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) ();
    // Write address channel
    logic [ID_WIDTH-1:0]     AWID;
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [7:0]              AWLEN;
    logic [2:0]              AWSIZE;
    logic [1:0]              AWBURST;
    logic                    AWLOCK;
    logic [3:0]              AWCACHE;
    logic [2:0]              AWPROT;
    logic [3:0]              AWQOS;
    logic [3:0]              AWREGION;
    logic                    AWVALID;
    logic                    AWREADY;
    // Write data channel
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WLAST;
    logic                    WVALID;
    logic                    WREADY;
    // Write response channel
    logic [ID_WIDTH-1:0]     BID;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    // Read address channel
    logic [ID_WIDTH-1:0]     ARID;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [7:0]              ARLEN;
    logic [2:0]              ARSIZE;
    logic [1:0]              ARBURST;
    logic                    ARLOCK;
    logic [3:0]              ARCACHE;
    logic [2:0]              ARPROT;
    logic [3:0]              ARQOS;
    logic [3:0]              ARREGION;
    logic                    ARVALID;
    logic                    ARREADY;
    // Read data channel
    logic [ID_WIDTH-1:0]     RID;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RLAST;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS, AWREGION, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS, AWREGION, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );
endinterface

// File: rtl/axi4_burst_reader.sv
// axi4_burst_reader: single-ID AXI4 read initiator. A (start address, beat count)
// command is split into INCR bursts of at most MAX_BURST_LEN beats that never cross
// a 4KB page; read data is passed straight through to a valid/ready stream.
// Optional build macro: AXI4_BURST_READER_RLAST_CHECK_EN (flag RLAST that disagrees
// with the expected final beat of a burst as an error).
module axi4_burst_reader #(
    parameter int AXI_ADDRESS_WIDTH = 32,
    parameter int AXI_DATA_WIDTH    = 32,
    parameter int AXI_ID_WIDTH      = 4,
    parameter int AXI_ID            = 0,
    parameter int MAX_BURST_LEN     = 16,
    parameter int COUNT_WIDTH       = 16
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [AXI_ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [COUNT_WIDTH-1:0]       cmd_count,
    output logic                         dat_valid,
    input  logic                         dat_ready,
    output logic [AXI_DATA_WIDTH-1:0]    dat_data,
    output logic                         dat_last,
    output logic                         done,
    output logic                         err,
    axi4_if.master                       m
);
    localparam int BYTES    = AXI_DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(BYTES);
    localparam logic [AXI_ADDRESS_WIDTH-1:0] ADDR_ALIGN_MASK = ~AXI_ADDRESS_WIDTH'(BYTES - 1);
    localparam logic [AXI_ADDRESS_WIDTH-1:0] ADDR_STEP       = AXI_ADDRESS_WIDTH'(BYTES);
    localparam logic [AXI_ID_WIDTH-1:0]      ID_VAL          = AXI_ID_WIDTH'(AXI_ID);

    // The interface instance must carry the ID width this block was built for.
    generate
        if ($bits(m.ARID) != AXI_ID_WIDTH) begin : g_id_width_check
            $fatal(1, "axi4_burst_reader: AXI_ID_WIDTH does not match interface ARID width");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } state_t;

    state_t                         state_reg, state_next;
    logic [AXI_ADDRESS_WIDTH-1:0]   addr_reg, addr_next;
    logic [COUNT_WIDTH-1:0]         remaining_reg, remaining_next;
    logic [8:0]                     beats_reg, beats_next;
    logic                           err_reg, err_next;

    logic [31:0]                    page_words;
    logic [31:0]                    burst_beats;
    logic                           beat_bad;
    logic                           ar_valid;
    logic                           r_ready;

    // Length of the next burst: limited by words left, MAX_BURST_LEN and the 4KB page end.
    always_comb begin
        page_words  = (32'd4096 - {20'd0, addr_reg[11:0]}) >> ADDR_LSB;
        burst_beats = 32'(MAX_BURST_LEN);
        if (32'(remaining_reg) < burst_beats) begin
            burst_beats = 32'(remaining_reg);
        end
        if (page_words < burst_beats) begin
            burst_beats = page_words;
        end
    end

    // Per-beat response check: bad RRESP or foreign RID (and optionally misplaced RLAST).
    always_comb begin
        beat_bad = (m.RRESP != 2'b00) || (m.RID != ID_VAL);
`ifdef AXI4_BURST_READER_RLAST_CHECK_EN
        beat_bad = beat_bad || (m.RLAST != (beats_reg == 9'd1));
`endif
    end

    // State and datapath registers with synchronous reset; a reset abandons any burst.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= '0;
            remaining_reg <= '0;
            beats_reg     <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            remaining_reg <= remaining_next;
            beats_reg     <= beats_next;
            err_reg       <= err_next;
        end
    end

    // Next-state logic and handshake outputs; only one burst is ever outstanding.
    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        remaining_next = remaining_reg;
        beats_next     = beats_reg;
        err_next       = err_reg;
        cmd_ready      = 1'b0;
        ar_valid       = 1'b0;
        r_ready        = 1'b0;
        dat_valid      = 1'b0;
        dat_last       = 1'b0;
        done           = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_next      = cmd_addr & ADDR_ALIGN_MASK;
                    remaining_next = cmd_count;
                    err_next       = 1'b0;
                    state_next     = (cmd_count == '0) ? ST_DONE : ST_ADDR;
                end
            end
            ST_ADDR: begin
                // ARADDR/ARLEN derive from registers that do not move in this state.
                ar_valid = 1'b1;
                if (m.ARREADY) begin
                    beats_next = burst_beats[8:0];
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                r_ready   = dat_ready;
                dat_valid = m.RVALID;
                dat_last  = m.RVALID && (beats_reg == 9'd1) && (remaining_reg == COUNT_WIDTH'(1));
                if (m.RVALID && dat_ready) begin
                    beats_next     = beats_reg - 9'd1;
                    remaining_next = remaining_reg - COUNT_WIDTH'(1);
                    // Advancing one word per beat lands on addr + beats*BYTES at burst end.
                    addr_next      = addr_reg + ADDR_STEP;
                    if (beat_bad) begin
                        err_next = 1'b1;
                    end
                    if (beats_reg == 9'd1) begin
                        state_next = (remaining_reg == COUNT_WIDTH'(1)) ? ST_DONE : ST_ADDR;
                    end
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign dat_data = m.RDATA;
    assign err      = err_reg;

    // Read address channel
    assign m.ARID     = ID_VAL;
    assign m.ARADDR   = addr_reg;
    assign m.ARLEN    = 8'(burst_beats - 32'd1);
    assign m.ARSIZE   = 3'(ADDR_LSB);
    assign m.ARBURST  = 2'b01;
    assign m.ARLOCK   = 1'b0;
    assign m.ARCACHE  = 4'd0;
    assign m.ARPROT   = 3'd0;
    assign m.ARQOS    = 4'd0;
    assign m.ARREGION = 4'd0;
    assign m.ARVALID  = ar_valid;
    assign m.RREADY   = r_ready;

    // Write channels are never used by this reader.
    assign m.AWID     = '0;
    assign m.AWADDR   = '0;
    assign m.AWLEN    = 8'd0;
    assign m.AWSIZE   = 3'd0;
    assign m.AWBURST  = 2'b00;
    assign m.AWLOCK   = 1'b0;
    assign m.AWCACHE  = 4'd0;
    assign m.AWPROT   = 3'd0;
    assign m.AWQOS    = 4'd0;
    assign m.AWREGION = 4'd0;
    assign m.AWVALID  = 1'b0;
    assign m.WDATA    = '0;
    assign m.WSTRB    = '0;
    assign m.WLAST    = 1'b0;
    assign m.WVALID   = 1'b0;
    assign m.BREADY   = 1'b1;

    // Inputs and bits that are intentionally not consumed.
    logic unused_ok;
    assign unused_ok = &{1'b0, m.AWREADY, m.WREADY, m.BVALID, m.BID, m.BRESP, m.RLAST,
                         burst_beats[31:9]};
endmodule

// File: tb/tb_axi4_burst_reader.sv
// Testbench for axi4_burst_reader: table of commands with hand-computed AR bursts,
// a simple memory-image AXI slave, plus hand-written reset-mid-burst sequence.
module tb_axi4_burst_reader;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int IDW = 4;
    localparam int CW  = 16;
    localparam int NV  = 8;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [CW-1:0] cmd_count;
    logic          dat_valid;
    logic          dat_ready;
    logic [DW-1:0] dat_data;
    logic          dat_last;
    logic          done;
    logic          err;

    always #5 ACLK = ~ACLK;

    axi4_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IDW)) axi ();

    axi4_burst_reader #(
        .AXI_ADDRESS_WIDTH(AW),
        .AXI_DATA_WIDTH   (DW),
        .AXI_ID_WIDTH     (IDW),
        .AXI_ID           (0),
        .MAX_BURST_LEN    (16),
        .COUNT_WIDTH      (CW)
    ) dut (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr (cmd_addr),
        .cmd_count(cmd_count),
        .dat_valid(dat_valid),
        .dat_ready(dat_ready),
        .dat_data (dat_data),
        .dat_last (dat_last),
        .done     (done),
        .err      (err),
        .m        (axi)
    );

    typedef struct {
        logic [31:0] addr;
        int          count;
        logic [3:0]  rdy;       // dat_ready pattern, bit (cycle % 4)
        int          err_beat;  // 0-based beat given RRESP=SLVERR, -1 none
        bit          exp_err;
        int          nb;
        logic [31:0] ba0, ba1, ba2;
        logic [7:0]  bl0, bl1, bl2;
    } vec_t;

    vec_t tbl [NV];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   err_abs  = -1;

    // Slave state (written only by the slave process)
    logic        s_busy;
    logic [31:0] s_addr;
    int          s_left;
    int          s_beat_total;
    logic [31:0] ar_addr_q [$];
    logic [7:0]  ar_len_q  [$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h3C5A_00A5;
    endfunction

    function automatic vec_t mk(input logic [31:0] addr, input int count, input logic [3:0] rdy,
                                input int err_beat, input bit exp_err, input int nb,
                                input logic [31:0] a0, input logic [7:0] l0,
                                input logic [31:0] a1, input logic [7:0] l1,
                                input logic [31:0] a2, input logic [7:0] l2);
        vec_t v;
        v.addr = addr; v.count = count; v.rdy = rdy; v.err_beat = err_beat; v.exp_err = exp_err;
        v.nb = nb; v.ba0 = a0; v.bl0 = l0; v.ba1 = a1; v.bl1 = l1; v.ba2 = a2; v.bl2 = l2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // AXI read slave: ARREADY while idle, one burst at a time, data = mem_word(addr).
    initial begin : slave
        bit          ar_hs, r_hs, rst;
        logic [31:0] cap_a;
        logic [7:0]  cap_l;
        s_busy = 1'b0; s_addr = '0; s_left = 0; s_beat_total = 0;
        axi.AWREADY = 1'b0; axi.WREADY = 1'b0; axi.BVALID = 1'b0; axi.BID = '0; axi.BRESP = 2'b00;
        axi.ARREADY = 1'b0; axi.RVALID = 1'b0; axi.RDATA = '0; axi.RLAST = 1'b0;
        axi.RRESP = 2'b00; axi.RID = '0;
        forever begin
            @(negedge ACLK);
            rst   = ARESET;
            ar_hs = axi.ARVALID && axi.ARREADY;
            r_hs  = axi.RVALID && axi.RREADY;
            cap_a = axi.ARADDR;
            cap_l = axi.ARLEN;
            @(posedge ACLK);
            #1;
            if (rst) begin
                s_busy = 1'b0;
                s_left = 0;
            end else begin
                if (r_hs) begin
                    s_beat_total++;
                    s_addr = s_addr + 32'd4;
                    s_left--;
                    if (s_left == 0) s_busy = 1'b0;
                end
                if (ar_hs) begin
                    ar_addr_q.push_back(cap_a);
                    ar_len_q.push_back(cap_l);
                    s_busy = 1'b1;
                    s_addr = cap_a;
                    s_left = int'(cap_l) + 1;
                end
            end
            axi.ARREADY = !s_busy;
            axi.RVALID  = s_busy;
            axi.RDATA   = mem_word(s_addr);
            axi.RLAST   = s_busy && (s_left == 1);
            axi.RRESP   = (s_busy && s_beat_total == err_abs) ? 2'b10 : 2'b00;
            axi.RID     = '0;
        end
    end

    // Issue one command, follow it to done, then compare against the vector.
    task automatic run_cmd(input vec_t v, input int idx);
        logic [31:0] got_d [$];
        bit          got_l [$];
        logic [31:0] base;
        int ar0, cyc, done_cnt, done_lat, bp_bad, err_first, last_cnt, last_pos;
        bit err_at_accept, err_at_done, done_after, ready_after;
        logic [31:0] ea; logic [7:0] el;
        base = v.addr & ~32'h3;
        ar0 = ar_addr_q.size();
        cyc = 0; done_cnt = 0; done_lat = -1; bp_bad = 0; err_first = -1;
        err_at_accept = 1'b1; err_at_done = 1'b0; done_after = 1'b1; ready_after = 1'b0;
        @(posedge ACLK);
        #1;
        err_abs   = (v.err_beat < 0) ? -1 : s_beat_total + v.err_beat;
        cmd_valid = 1'b1;
        cmd_addr  = v.addr;
        cmd_count = CW'(v.count);
        dat_ready = v.rdy[0];
        @(negedge ACLK);
        chk($sformatf("v%0d_cmd_ready_idle", idx), cmd_ready, 1'b1);
        @(posedge ACLK);
        #1;
        cmd_valid = 1'b0;
        while (cyc < 400) begin
            @(negedge ACLK);
            if (cyc == 0) err_at_accept = err;
            if (err && err_first < 0) err_first = got_d.size();
            if (axi.RVALID) begin
                if (axi.RREADY !== dat_ready || dat_valid !== 1'b1 || dat_data !== axi.RDATA) bp_bad++;
            end else if (dat_valid !== 1'b0) begin
                bp_bad++;
            end
            if (dat_valid && dat_ready) begin
                got_d.push_back(dat_data);
                got_l.push_back(dat_last);
            end
            if (done) begin
                done_cnt++;
                if (done_lat < 0) begin
                    done_lat = cyc;
                    err_at_done = err;
                end
            end
            if (done_lat >= 0 && cyc == done_lat + 1) begin
                done_after  = done;
                ready_after = cmd_ready;
                break;
            end
            @(posedge ACLK);
            #1;
            cyc++;
            dat_ready = v.rdy[cyc % 4];
        end
        dat_ready = 1'b1;
        $display("cmd %0d: addr=0x%08h count=%0d bursts=%0d beats=%0d err=%0b done_at=%0d",
                 idx, v.addr, v.count, ar_addr_q.size() - ar0, got_d.size(), err_at_done, done_lat);
        chk($sformatf("v%0d_done_seen", idx), done_lat >= 0, 1'b1);
        chk($sformatf("v%0d_err_clear_on_accept", idx), err_at_accept, 1'b0);
        chk($sformatf("v%0d_burst_count", idx), ar_addr_q.size() - ar0, v.nb);
        for (int i = 0; i < v.nb && (ar0 + i) < ar_addr_q.size(); i++) begin
            ea = (i == 0) ? v.ba0 : (i == 1) ? v.ba1 : v.ba2;
            el = (i == 0) ? v.bl0 : (i == 1) ? v.bl1 : v.bl2;
            chk($sformatf("v%0d_burst%0d_araddr", idx, i), ar_addr_q[ar0 + i], ea);
            chk($sformatf("v%0d_burst%0d_arlen", idx, i), ar_len_q[ar0 + i], el);
        end
        chk($sformatf("v%0d_beat_count", idx), got_d.size(), v.count);
        for (int i = 0; i < got_d.size() && i < v.count; i++) begin
            chk($sformatf("v%0d_beat%0d_data", idx, i), got_d[i], mem_word(base + 32'(4 * i)));
        end
        last_cnt = 0; last_pos = -1;
        for (int i = 0; i < got_l.size(); i++) begin
            if (got_l[i]) begin
                last_cnt++;
                if (last_pos < 0) last_pos = i;
            end
        end
        chk($sformatf("v%0d_last_count", idx), last_cnt, (v.count > 0) ? 1 : 0);
        if (v.count > 0) chk($sformatf("v%0d_last_pos", idx), last_pos, v.count - 1);
        chk($sformatf("v%0d_done_pulses", idx), done_cnt, 1);
        chk($sformatf("v%0d_done_one_cycle", idx), done_after, 1'b0);
        chk($sformatf("v%0d_cmd_ready_after_done", idx), ready_after, 1'b1);
        chk($sformatf("v%0d_err_at_done", idx), err_at_done, v.exp_err);
        chk($sformatf("v%0d_passthrough_violations", idx), bp_bad, 0);
        if (v.exp_err) chk($sformatf("v%0d_err_after_beat", idx), err_first, v.err_beat + 1);
        if (v.count == 0) chk($sformatf("v%0d_zero_done_latency", idx), done_lat <= 1, 1'b1);
    endtask

    initial begin : main
        int nb;
        ARESET = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_count = '0; dat_ready = 1'b1;
        tbl[0] = mk(32'h0000_1000, 40, 4'b1111, -1, 0, 3, 32'h1000, 8'd15, 32'h1040, 8'd15, 32'h1080, 8'd7);
        tbl[1] = mk(32'h0000_0FF8,  4, 4'b1111, -1, 0, 2, 32'h0FF8, 8'd1,  32'h1000, 8'd1,  32'h0,    8'd0);
        tbl[2] = mk(32'h0000_0FFB,  4, 4'b1111, -1, 0, 2, 32'h0FF8, 8'd1,  32'h1000, 8'd1,  32'h0,    8'd0);
        tbl[3] = mk(32'h0000_0000,  8, 4'b1001, -1, 0, 1, 32'h0000, 8'd7,  32'h0,    8'd0,  32'h0,    8'd0);
        tbl[4] = mk(32'h0000_0100,  5, 4'b1111,  2, 1, 1, 32'h0100, 8'd4,  32'h0,    8'd0,  32'h0,    8'd0);
        tbl[5] = mk(32'h0000_0000,  0, 4'b1111, -1, 0, 0, 32'h0,    8'd0,  32'h0,    8'd0,  32'h0,    8'd0);
        tbl[6] = mk(32'hFFFF_FFF8,  4, 4'b1111, -1, 0, 2, 32'hFFFF_FFF8, 8'd1, 32'h0, 8'd1, 32'h0,    8'd0);
        tbl[7] = mk(32'h0000_1FC0, 20, 4'b0110, -1, 0, 2, 32'h1FC0, 8'd15, 32'h2000, 8'd3,  32'h0,    8'd0);

        repeat (3) @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("reset_cmd_ready", cmd_ready, 1'b1);
        chk("reset_arvalid", axi.ARVALID, 1'b0);
        chk("reset_rready", axi.RREADY, 1'b0);
        chk("reset_dat_valid", dat_valid, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_err", err, 1'b0);
        chk("tie_awvalid_wvalid_bready", {axi.AWVALID, axi.WVALID, axi.BREADY}, 3'b001);
        chk("tie_arburst_arsize_arid", {axi.ARBURST, axi.ARSIZE, axi.ARID}, {2'b01, 3'd2, 4'd0});

        for (int i = 0; i < NV; i++) run_cmd(tbl[i], i);

        // Reset while beat 2 of a 16-beat burst is on the bus.
        @(posedge ACLK);
        #1;
        cmd_valid = 1'b1; cmd_addr = 32'h3000; cmd_count = CW'(16); dat_ready = 1'b1;
        @(negedge ACLK);
        @(posedge ACLK);
        #1;
        cmd_valid = 1'b0;
        nb = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge ACLK);
            if (dat_valid && dat_ready) nb++;
            if (nb == 1) break;
            @(posedge ACLK);
            #1;
        end
        chk("rst_mid_reached_beat1", nb, 1);
        @(posedge ACLK);
        #1;
        ARESET = 1'b1;
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        @(negedge ACLK);
        $display("reset mid-burst: arvalid=%0b rready=%0b dat_valid=%0b cmd_ready=%0b",
                 axi.ARVALID, axi.RREADY, dat_valid, cmd_ready);
        chk("rst_mid_arvalid", axi.ARVALID, 1'b0);
        chk("rst_mid_rready", axi.RREADY, 1'b0);
        chk("rst_mid_dat_valid", dat_valid, 1'b0);
        chk("rst_mid_cmd_ready", cmd_ready, 1'b1);
        run_cmd(mk(32'h2000, 1, 4'b1111, -1, 0, 1, 32'h2000, 8'd0, 32'h0, 8'd0, 32'h0, 8'd0), 99);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
